// File: rtl/adc_fifo_stream_sched_if.sv
// rtl/adc_fifo_stream_sched_if.sv - USB slave-FIFO stream-in pin bundle
//
// Purpose: groups the slave-FIFO write-side pins used by adc_fifo_stream_sched.
// Signals:
//   fdata    16-bit FIFO data word
//   faddr    FIFO endpoint address
//   slwr     write strobe, active low
//   pkt_end  packet commit strobe, active low
//   flagd    FIFO space available (1 = not full)
// Modports:
//   master   the writer (drives data/strobes, observes flagd)
//   slave    the FIFO side (observes data/strobes, drives flagd)

interface adc_fifo_stream_sched_if;
    logic [15:0] fdata;
    logic [1:0]  faddr;
    logic        slwr;
    logic        pkt_end;
    logic        flagd;

    modport master (
        output fdata,
        output faddr,
        output slwr,
        output pkt_end,
        input  flagd
    );

    modport slave (
        input  fdata,
        input  faddr,
        input  slwr,
        input  pkt_end,
        output flagd
    );
endinterface

// File: rtl/adc_fifo_stream_sched.sv
// rtl/adc_fifo_stream_sched.sv - multi-channel ADC sample sets into slave-FIFO stream
//
// Purpose: captures one conversion set per sample_valid pulse, walks the
// channels enabled in the armed mask in ascending order and writes one tagged
// 16-bit word per channel into the USB slave FIFO, honouring the FIFO full
// flag. On stop, a partially filled packet is committed with pkt_end.
//
// Ports:
//   clk_out_0     interface clock
//   reset_n       asynchronous, active-low reset
//   enable        level, stream request
//   sync          host sync; arming only possible while high
//   ch_mask       channel enable mask, bit i = channel i
//   sample_valid  one-cycle pulse, ch_data holds a new conversion set
//   ch_data       packed samples, channel 0 in [SAMPLE_W-1:0]
//   fifo          slave-FIFO pins (master modport): fdata, faddr, slwr,
//                 pkt_end, flagd
//   overrun       sticky, a sample set was dropped
//   words_sent    total words written, wraps modulo 2^16
//
// Word format: {sample, zero pad, channel[2:0]}; SAMPLE_W must be <= 13.

module adc_fifo_stream_sched #(
    parameter int NUM_CH    = 8,
    parameter int SAMPLE_W  = 12,
    parameter int PKT_WORDS = 256
) (
    input  logic                         clk_out_0,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic                         sync,
    input  logic [NUM_CH-1:0]            ch_mask,
    input  logic                         sample_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0]   ch_data,
    adc_fifo_stream_sched_if.master      fifo,
    output logic                         overrun,
    output logic [15:0]                  words_sent
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PKT_W = $clog2(PKT_WORDS);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_SAMPLE = 2'd1,
        WRITE       = 2'd2,
        FLUSH       = 2'd3
    } state_t;

    state_t                      state_q;
    state_t                      state_d;

    logic [NUM_CH-1:0]           mask_q;
    logic [NUM_CH*SAMPLE_W-1:0]  shadow_q;
    logic [CH_W-1:0]             ptr_q;
    logic [PKT_W-1:0]            pkt_cnt_q;

    // FSM decode strobes
    logic                        arm;
    logic                        capture;
    logic                        wr;
    logic                        commit;

    // channel walk helpers
    logic [CH_W-1:0]             first_ptr;
    logic [CH_W-1:0]             next_ptr;
    logic                        has_next;

    logic [15:0]                 fdata_w;

    // Lowest set bit of the armed mask, and the lowest set bit above ptr_q.
    // Loops run downward so the last hit is the lowest qualifying channel.
    always_comb begin
        first_ptr = '0;
        next_ptr  = ptr_q;
        has_next  = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                first_ptr = CH_W'(i);
            end
            if (mask_q[i] && (i > int'(ptr_q))) begin
                next_ptr = CH_W'(i);
                has_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_out_0 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        arm     = 1'b0;
        capture = 1'b0;
        wr      = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && sync && fifo.flagd && (ch_mask != '0)) begin
                    arm     = 1'b1;
                    state_d = WAIT_SAMPLE;
                end
            end
            WAIT_SAMPLE: begin
                // A sample arriving together with enable low is still streamed;
                // the stop is seen again once the set has been written.
                if (sample_valid) begin
                    capture = 1'b1;
                    state_d = WRITE;
                end else if (!enable) begin
                    state_d = FLUSH;
                end
            end
            WRITE: begin
                if (fifo.flagd) begin
                    wr = 1'b1;
                    if (!has_next) begin
                        state_d = WAIT_SAMPLE;
                    end
                end
            end
            FLUSH: begin
                // An exactly full packet has already been committed by the FIFO.
                if (pkt_cnt_q == '0) begin
                    state_d = IDLE;
                end else if (fifo.flagd) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_out_0 or negedge reset_n) begin
        if (!reset_n) begin
            mask_q     <= '0;
            shadow_q   <= '0;
            ptr_q      <= '0;
            pkt_cnt_q  <= '0;
            words_sent <= '0;
            overrun    <= 1'b0;
        end else begin
            if (arm) begin
                mask_q  <= ch_mask;
                overrun <= 1'b0;
            end
            if (capture) begin
                shadow_q <= ch_data;
                ptr_q    <= first_ptr;
            end
            if (wr) begin
                ptr_q      <= next_ptr;
                words_sent <= words_sent + 16'd1;
                // PKT_WORDS is a power of two, so the natural wrap is the packet boundary.
                pkt_cnt_q  <= pkt_cnt_q + 1'b1;
            end
            if (commit) begin
                pkt_cnt_q <= '0;
            end
            // Shadow is busy for the whole set, including its last write cycle.
            if ((state_q == WRITE) && sample_valid) begin
                overrun <= 1'b1;
            end
        end
    end

    // Data word built from registers only, so fdata never glitches on inputs.
    always_comb begin
        fdata_w                  = '0;
        fdata_w[15 -: SAMPLE_W]  = shadow_q[int'(ptr_q) * SAMPLE_W +: SAMPLE_W];
        fdata_w[2:0]             = 3'(ptr_q);
    end

    assign fifo.fdata   = fdata_w;
    assign fifo.faddr   = 2'b10;
    assign fifo.slwr    = ~wr;
    assign fifo.pkt_end = ~commit;

endmodule
